sw_ctrl_pulse: RTL and testbench
================================

Name: sw_ctrl_pulse

Overview:
Upstream control stage for the stopwatch digit chain. It synchronises and debounces the four front-panel buttons, runs an IDLE/RUN/PAUSE state machine and divides the system clock into a once-per-second tick. It emits single-cycle add/sub/clear strobes that drive the units-digit adder; the digit adders cascade carries among themselves downstream.

Parameters:
TICK_DIV, 50000000, clock cycles per counting tick (minimum 2).
DB_CYCLES, 1000000, consecutive stable synchronised cycles required before a button level is accepted (minimum 1).

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  synchronous, active-high reset
btn_ss  input  1  raw start/stop button, asynchronous, active-high
btn_clr  input  1  raw clear button, asynchronous, active-high
btn_up  input  1  raw manual-increment button, asynchronous, active-high
btn_dn  input  1  raw manual-decrement button, asynchronous, active-high
count_dir  input  1  level, 0 = count up, 1 = count down; sampled only at tick
add  output  1  one-cycle strobe: increment units digit
sub  output  1  one-cycle strobe: decrement units digit
clr  output  1  one-cycle strobe: zero all digits
running  output  1  high while state = RUN

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; tick counter=0.
  - Synchronisers, debounced levels and debounce counters are cleared to 0.
  - add=sub=clr=running=0 from the following cycle.
  - rst mid-RUN aborts the run with no strobe emitted.
- Input conditioning, per button:
  - 2-FF synchroniser, then a debounce counter.
  - Counter clears whenever the synchronised value equals the debounced level, or changes from the previous cycle.
  - When it reaches DB_CYCLES-1 with the value still differing, the debounced level takes the synchronised value and the counter clears.
  - A press is a 0->1 edge of the debounced level, one cycle wide. Releases generate nothing.
  - Holding a button gives exactly one press. There is no auto-repeat.
- Press priority in a single cycle: clr > ss > up/dn.
  - up and dn pressed in the same cycle cancel each other; no strobe.
  - Lower-priority presses in a cycle where a higher-priority press is taken are discarded, not queued.
- FSM:
  - IDLE: ss press -> RUN. up press -> add strobe. dn press -> sub strobe.
  - RUN: ss press -> PAUSE. up/dn presses are ignored.
  - PAUSE: ss press -> RUN. up press -> add strobe. dn press -> sub strobe.
  - Any state: clr press -> IDLE, clr strobe, tick counter=0. A clr press in RUN also discards any tick in the same cycle.
- Tick counter:
  - Increments only in RUN. Holds its value in PAUSE, so the partial second is preserved. Zeroed in IDLE and on clear.
  - On reaching TICK_DIV-1 it wraps to 0 in the same step and generates a tick.
  - Tick -> add strobe if count_dir=0, sub strobe if count_dir=1.
  - First tick occurs TICK_DIV cycles after entering RUN from IDLE.
- Output timing:
  - All outputs are registered. A strobe appears on the cycle after the press or tick is decided, and is high for exactly one cycle.
  - running rises the cycle after the RUN transition.
  - add and sub are never high together. clr is never high together with add or sub.
- Collisions:
  - An ss press that leaves RUN in the same cycle the counter wraps: the tick is still emitted and the counter holds at 0.
  - An ss press entering RUN: counting starts the next cycle.
- Wrap and range are not checked here; digit limits and carries are owned by the digit adders.

Test Plan:
- TICK_DIV=10, DB_CYCLES=4, rst held 3 cycles -> add, sub, clr and running are all 0; state is IDLE.
- btn_ss high 8 cycles from IDLE, count_dir=0 -> running=1; add pulses exactly every 10 cycles; 5 pulses in 50 cycles; sub stays 0.
- btn_ss glitch of 2 cycles (shorter than DB_CYCLES) -> no state change and no strobes.
- RUN with counter at 6, then press ss (PAUSE) and wait 30 cycles, then press ss (RUN) -> first add 4 counting cycles after re-entering RUN.
- PAUSE: press up 3 separate times and dn once -> exactly 3 add and 1 sub strobes. The same presses in RUN -> none.
- In RUN, clr and ss debounced in the same cycle -> single clr strobe; state=IDLE; running=0; no add for 20 cycles.
- RUN with count_dir=1 -> sub every 10 cycles; add stays 0. Raise rst mid-count -> no further strobes; counter restarts from 0.

Source files
------------

// File: rtl/sw_ctrl_pulse.sv
`default_nettype none
// ============================================================================
// Module   : sw_ctrl_pulse
// Desc     : Stopwatch control stage. Conditions the front-panel buttons, runs
//            the IDLE/RUN/PAUSE controller and emits add/sub/clr strobes.
// Revision : 1.0 - initial release
// ============================================================================
module sw_ctrl_pulse #(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_ss,
    input  logic btn_clr,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic count_dir,
    output logic add,
    output logic sub,
    output logic clr,
    output logic running
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
    localparam int c_NBTN = 4;
    localparam int c_SS   = 0;
    localparam int c_CLR  = 1;
    localparam int c_UP   = 2;
    localparam int c_DN   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic [c_NBTN-1:0] w_btn_raw;
    logic [c_NBTN-1:0] r_sync1;
    logic [c_NBTN-1:0] r_sync2;
    logic [c_NBTN-1:0] r_sync3;
    logic [c_NBTN-1:0] w_db;
    logic [c_NBTN-1:0] r_db_d;
    logic [c_NBTN-1:0] w_press;

    assign w_btn_raw = {btn_dn, btn_up, btn_clr, btn_ss};

    // r_sync3 is the previous synchronised value, used to restart the debounce
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_db_d  <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_db_d  <= w_db;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < c_NBTN; gi++) begin : g_btn
            logic [c_DB_W-1:0] r_cnt;
            logic              r_db;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if ((r_sync2[gi] == r_db) || (r_sync2[gi] != r_sync3[gi])) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_cnt <= '0;
                    r_db  <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_db[gi] = r_db;
        end
    endgenerate

    assign w_press = w_db & ~r_db_d;

    logic w_press_ss;
    logic w_press_clr;
    logic w_up_only;
    logic w_dn_only;

    assign w_press_ss  = w_press[c_SS];
    assign w_press_clr = w_press[c_CLR];
    assign w_up_only   = w_press[c_UP] & ~w_press[c_DN];
    assign w_dn_only   = w_press[c_DN] & ~w_press[c_UP];

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_TICK_W-1:0] w_tick_cnt_nxt;
    logic                w_tick;
    logic                w_add_nxt;
    logic                w_sub_nxt;
    logic                w_clr_nxt;
    logic                r_add;
    logic                r_sub;
    logic                r_clr;
    logic                r_running;

    assign w_tick = (r_state == ST_RUN) && (r_tick_cnt == c_TICK_LAST);

    // The counter keeps stepping on the cycle an ss press leaves RUN, so a
    // coincident wrap still produces its tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_add_nxt      = 1'b0;
        w_sub_nxt      = 1'b0;
        w_clr_nxt      = 1'b0;

        case (r_state)
            ST_RUN:   w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
            ST_PAUSE: w_tick_cnt_nxt = r_tick_cnt;
            default:  w_tick_cnt_nxt = '0;
        endcase

        if (w_press_clr) begin
            w_state_nxt    = ST_IDLE;
            w_tick_cnt_nxt = '0;
            w_clr_nxt      = 1'b1;
        end else begin
            if (w_tick) begin
                w_add_nxt = ~count_dir;
                w_sub_nxt = count_dir;
            end
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (w_press_ss) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_add_nxt = w_up_only;
                        w_sub_nxt = w_dn_only;
                    end
                end
                ST_RUN: begin
                    if (w_press_ss) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_tick_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_add      <= 1'b0;
            r_sub      <= 1'b0;
            r_clr      <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_add      <= w_add_nxt;
            r_sub      <= w_sub_nxt;
            r_clr      <= w_clr_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
        end
    end

    assign add     = r_add;
    assign sub     = r_sub;
    assign clr     = r_clr;
    assign running = r_running;

endmodule

`default_nettype wire

// File: tb/tb_sw_ctrl_pulse.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sw_ctrl_pulse
// Desc     : Directed self-checking bench for sw_ctrl_pulse (TICK_DIV=10,
//            DB_CYCLES=4). A raise at cycle x is decided at posedge x+8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_ctrl_pulse;

    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;
    localparam logic [3:0] c_SS  = 4'b0001;
    localparam logic [3:0] c_CLR = 4'b0010;
    localparam logic [3:0] c_UP  = 4'b0100;
    localparam logic [3:0] c_DN  = 4'b1000;

    logic clk;
    logic rst;
    logic btn_ss;
    logic btn_clr;
    logic btn_up;
    logic btn_dn;
    logic count_dir;
    logic add;
    logic sub;
    logic clr;
    logic running;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int n_run_cyc = 0;
    int n_overlap = 0;
    logic run_q   = 1'b0;
    int add_q[$];
    int sub_q[$];
    int clr_q[$];
    int rise_q[$];
    int b_add, b_sub, b_clr, b_rise, b_run;

    sw_ctrl_pulse #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_ss    (btn_ss),
        .btn_clr   (btn_clr),
        .btn_up    (btn_up),
        .btn_dn    (btn_dn),
        .count_dir (count_dir),
        .add       (add),
        .sub       (sub),
        .clr       (clr),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log: cycle number of every high strobe cycle and running rise
    always @(negedge clk) begin
        if (add === 1'b1) add_q.push_back(cyc);
        if (sub === 1'b1) sub_q.push_back(cyc);
        if (clr === 1'b1) clr_q.push_back(cyc);
        if (running === 1'b1) begin
            n_run_cyc++;
            if (!run_q) rise_q.push_back(cyc);
        end
        if (((add & sub) | (clr & (add | sub))) === 1'b1) n_overlap++;
        run_q = (running === 1'b1);
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic mark();
        b_add  = add_q.size();
        b_sub  = sub_q.size();
        b_clr  = clr_q.size();
        b_rise = rise_q.size();
        b_run  = n_run_cyc;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        {btn_dn, btn_up, btn_clr, btn_ss} = mask;
        repeat (hold) step();
        {btn_dn, btn_up, btn_clr, btn_ss} = 4'b0000;
    endtask

    function automatic int at_q(input int q[$], input int idx);
        if (idx >= 0 && idx < q.size()) return q[idx];
        return -1000;
    endfunction

    initial begin
        int x;
        int rise;
        rst = 1'b1;
        {btn_dn, btn_up, btn_clr, btn_ss} = 4'b0000;
        count_dir = 1'b0;

        repeat (3) step();
        check("reset_add", add, 0);
        check("reset_sub", sub, 0);
        check("reset_clr", clr, 0);
        check("reset_running", running, 0);
        rst = 1'b0;
        step();

        // 2-cycle glitch on ss: rejected
        mark();
        press(c_SS, 2);
        repeat (20) step();
        check("glitch_add", add_q.size() - b_add, 0);
        check("glitch_sub", sub_q.size() - b_sub, 0);
        check("glitch_clr", clr_q.size() - b_clr, 0);
        check("glitch_run", n_run_cyc - b_run, 0);

        // up+dn together cancel
        mark();
        press(c_UP | c_DN, 6);
        repeat (12) step();
        check("cancel_add", add_q.size() - b_add, 0);
        check("cancel_sub", sub_q.size() - b_sub, 0);

        // manual up in IDLE, held: one add only
        mark();
        x = cyc;
        press(c_UP, 6);
        repeat (12) step();
        check("idle_up_cnt", add_q.size() - b_add, 1);
        check("idle_up_time", at_q(add_q, b_add) - x, 8);

        // clr in IDLE
        mark();
        x = cyc;
        press(c_CLR, 6);
        repeat (12) step();
        check("idle_clr_cnt", clr_q.size() - b_clr, 1);
        check("idle_clr_time", at_q(clr_q, b_clr) - x, 8);

        // start counting up
        mark();
        x = cyc;
        press(c_SS, 8);
        repeat (50) step();
        rise = at_q(rise_q, b_rise);
        check("run_rise", rise - x, 8);
        check("first_tick", at_q(add_q, b_add) - rise, 10);
        check("tick_count", add_q.size() - b_add, 5);
        check("tick_span", at_q(add_q, add_q.size() - 1) - at_q(add_q, b_add), 40);
        check("run_sub", sub_q.size() - b_sub, 0);

        // pause with counter at 6 (last wrap was at the current cycle)
        repeat (8) step();
        mark();
        x = cyc;
        press(c_SS, 8);
        check("pause_running", running, 0);
        check("pause_prior_tick", add_q.size() - b_add, 1);
        check("pause_prior_time", at_q(add_q, b_add) - x, 2);
        mark();
        repeat (30) step();
        check("pause_idle_add", add_q.size() - b_add, 0);
        check("pause_idle_run", n_run_cyc - b_run, 0);

        // manual presses in PAUSE
        mark();
        repeat (3) begin
            press(c_UP, 6);
            repeat (10) step();
        end
        press(c_DN, 6);
        repeat (10) step();
        press(c_UP | c_DN, 6);
        repeat (10) step();
        check("pause_man_add", add_q.size() - b_add, 3);
        check("pause_man_sub", sub_q.size() - b_sub, 1);
        check("pause_man_clr", clr_q.size() - b_clr, 0);

        // resume: 4 counting cycles remain
        mark();
        x = cyc;
        press(c_SS, 8);
        repeat (8) step();
        check("resume_rise", at_q(rise_q, b_rise) - x, 8);
        check("resume_tick", at_q(add_q, b_add) - x, 12);

        // manual presses ignored in RUN; ticks at x+22..x+72
        mark();
        repeat (3) begin
            press(c_UP, 6);
            repeat (10) step();
        end
        press(c_DN, 6);
        repeat (10) step();
        check("run_man_add", add_q.size() - b_add, 6);
        check("run_man_sub", sub_q.size() - b_sub, 0);
        check("run_man_run", n_run_cyc - b_run, 64);

        // clr+ss together, decided on a tick cycle
        repeat (4) step();
        mark();
        x = cyc;
        press(c_CLR | c_SS, 8);
        repeat (20) step();
        check("clr_cnt", clr_q.size() - b_clr, 1);
        check("clr_time", at_q(clr_q, b_clr) - x, 8);
        check("clr_add", add_q.size() - b_add, 0);
        check("clr_sub", sub_q.size() - b_sub, 0);
        check("clr_running", running, 0);
        check("clr_run_cyc", n_run_cyc - b_run, 7);

        // count down
        count_dir = 1'b1;
        mark();
        x = cyc;
        press(c_SS, 8);
        repeat (22) step();
        rise = at_q(rise_q, b_rise);
        check("dn_rise", rise - x, 8);
        check("dn_first", at_q(sub_q, b_sub) - rise, 10);
        check("dn_cnt", sub_q.size() - b_sub, 2);
        check("dn_add", add_q.size() - b_add, 0);

        // reset mid-count
        rst = 1'b1;
        step();
        rst = 1'b0;
        mark();
        repeat (30) step();
        check("rst_sub", sub_q.size() - b_sub, 0);
        check("rst_add", add_q.size() - b_add, 0);
        check("rst_clr", clr_q.size() - b_clr, 0);
        check("rst_run", n_run_cyc - b_run, 0);

        // restart after reset: counter starts from 0
        mark();
        x = cyc;
        press(c_SS, 8);
        repeat (12) step();
        rise = at_q(rise_q, b_rise);
        check("restart_rise", rise - x, 8);
        check("restart_first", at_q(sub_q, b_sub) - rise, 10);

        check("overlap", n_overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
